gpr_wb: RTL and testbench
=========================

GPR_WB -- requirements
Module: gpr_wb

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (32), data width of results and GPR write data.
REQ-002 Parameter GPRS_WIDTH, default `GPRS_WIDTH (5), register-id width.
REQ-003 Parameter DEPTH, default 4, number of writeback queue entries; must be a power of 2 and at least 2.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 i_sys_clk  in  1  system clock; all state changes on its rising edge.
REQ-006 i_sys_rst_n  in  1  synchronous, active-high reset; 1 = reset.
REQ-007 i_lsu_valid / o_lsu_ready  in/out  1/1  LSU result handshake.
REQ-008 i_lsu_id / i_lsu_data  in  GPRS_WIDTH/DATA_WIDTH  LSU destination id and data.
REQ-009 i_alu_valid / o_alu_ready  in/out  1/1  ALU result handshake.
REQ-010 i_alu_id / i_alu_data  in  GPRS_WIDTH/DATA_WIDTH  ALU destination id and data.
REQ-011 i_wb_stall  in  1  while 1, no queue entry is popped.
REQ-012 i_wb_qry_rs1_id / i_wb_qry_rs2_id  in  GPRS_WIDTH each  hazard query ids.
REQ-013 o_wb_qry_rs1_busy / o_wb_qry_rs2_busy  out  1 each  pending-write flags for the query ids.
REQ-014 o_gpr_wr_en / o_gpr_wr_id / o_gpr_wr_data  out  1/GPRS_WIDTH/DATA_WIDTH  drive the GPR write port.
REQ-015 o_wb_count  out  $clog2(DEPTH)+1  number of valid queue entries.
REQ-016 o_wb_idle  out  1  queue empty and o_gpr_wr_en == 0.

Function
REQ-017 Transfer rule: a port transfers when valid && ready in the same cycle.
REQ-018 o_lsu_ready shall be 1 whenever count < DEPTH.
REQ-019 o_alu_ready shall be 1 whenever count < DEPTH and i_lsu_valid == 0, giving fixed LSU priority and at most one accept per cycle.
REQ-020 A transferred result with id 0 shall be consumed and discarded, with no enqueue and no count change.
REQ-021 A transferred result with a nonzero id shall be written at the tail, and the tail pointer shall advance modulo DEPTH.
REQ-022 Pop: in any cycle with count > 0 and i_wb_stall == 0, the head shall be popped and the head pointer shall advance modulo DEPTH.
REQ-023 The popped entry shall appear on o_gpr_wr_en=1 / o_gpr_wr_id / o_gpr_wr_data in the next cycle.
REQ-024 In cycles with no pop, o_gpr_wr_en shall be 0, and o_gpr_wr_id / o_gpr_wr_data shall hold their last values.
REQ-025 Latency: with an empty queue and no stall, an accept in cycle N gives o_gpr_wr_en=1 in cycle N+2.
REQ-026 Ordering: GPR writes shall occur in strict acceptance order; same-id entries are never merged or reordered.
REQ-027 Simultaneous push and pop shall leave count unchanged.
REQ-028 When full (count == DEPTH), both readies shall be 0, even if a pop occurs in the same cycle (no full pass-through).
REQ-029 Empty queue with no pop shall produce no write; i_wb_stall has no effect on an empty queue.
REQ-030 o_wb_qry_rsX_busy shall be 1 iff the id is nonzero and it matches either any valid queue entry or the output stage while o_gpr_wr_en == 1.
REQ-031 Busy flags shall be combinational from registered state only and shall be independent of same-cycle inputs.
REQ-032 Busy for id 0 shall always be 0.
REQ-033 Pointers and count shall wrap without a gap, and the queue shall keep operating indefinitely.

Reset
REQ-034 While i_sys_rst_n == 1 at a clock edge, the block shall clear head, tail and count.
REQ-035 The same reset shall drive o_gpr_wr_en=0, o_gpr_wr_id=0 and o_gpr_wr_data=0.
REQ-036 Reset shall discard all queue entries, including any in flight.
REQ-037 After that edge, readies shall be 1 (o_alu_ready subject to i_lsu_valid), busy flags 0, o_wb_count 0 and o_wb_idle 1.
REQ-038 Reset shall override a same-cycle accept and a same-cycle pop.
REQ-039 Queue storage contents need not be reset.

Verification
REQ-040 Basic path: ALU id=5 data=0xDEADBEEF accepted at cycle 0 -> o_gpr_wr_en=1, id=5, data=0xDEADBEEF at cycle 2; rs1=5 busy in cycles 1-2, 0 at cycle 3.
REQ-041 Priority: LSU(id=3, 0x11) and ALU(id=4, 0x22) both valid -> o_alu_ready=0; LSU write first, then ALU, in consecutive write cycles.
REQ-042 Full/stall: i_wb_stall=1 with 4 accepts -> count=4, both readies 0.
REQ-043 Full/stall release: release stall -> 4 writes on consecutive cycles in accept order; readies return to 1 after the first pop.
REQ-044 x0 drop: ALU id=0 data=0xFFFFFFFF accepted -> count stays 0, no o_gpr_wr_en pulse, busy for id 0 stays 0.
REQ-045 Wrap/same-id: 10 accepts of id=7 with data 1..10, interleaved with pops -> writes of 1..10 in order, with busy(7)=1 until the last write cycle ends.
REQ-046 Reset mid-operation: reset with count=3 and a write in flight -> the next cycle shows count=0, o_gpr_wr_en=0, o_wb_idle=1 and no further writes.

Source files
------------

// File: rtl/gpr_wb_if.sv
// Handshake, query and GPR write-port bundle for the writeback queue.
// The slave modport is the gpr_wb view; master is the driving environment.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif

interface gpr_wb_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int GPRS_WIDTH = `GPRS_WIDTH,
    parameter int DEPTH      = 4
);
    logic                    i_lsu_valid;
    logic                    o_lsu_ready;
    logic [GPRS_WIDTH-1:0]   i_lsu_id;
    logic [DATA_WIDTH-1:0]   i_lsu_data;
    logic                    i_alu_valid;
    logic                    o_alu_ready;
    logic [GPRS_WIDTH-1:0]   i_alu_id;
    logic [DATA_WIDTH-1:0]   i_alu_data;
    logic                    i_wb_stall;
    logic [GPRS_WIDTH-1:0]   i_wb_qry_rs1_id;
    logic [GPRS_WIDTH-1:0]   i_wb_qry_rs2_id;
    logic                    o_wb_qry_rs1_busy;
    logic                    o_wb_qry_rs2_busy;
    logic                    o_gpr_wr_en;
    logic [GPRS_WIDTH-1:0]   o_gpr_wr_id;
    logic [DATA_WIDTH-1:0]   o_gpr_wr_data;
    logic [$clog2(DEPTH):0]  o_wb_count;
    logic                    o_wb_idle;

    modport slave (
        input  i_lsu_valid, i_lsu_id, i_lsu_data,
        input  i_alu_valid, i_alu_id, i_alu_data,
        input  i_wb_stall, i_wb_qry_rs1_id, i_wb_qry_rs2_id,
        output o_lsu_ready, o_alu_ready,
        output o_wb_qry_rs1_busy, o_wb_qry_rs2_busy,
        output o_gpr_wr_en, o_gpr_wr_id, o_gpr_wr_data,
        output o_wb_count, o_wb_idle
    );

    modport master (
        output i_lsu_valid, i_lsu_id, i_lsu_data,
        output i_alu_valid, i_alu_id, i_alu_data,
        output i_wb_stall, i_wb_qry_rs1_id, i_wb_qry_rs2_id,
        input  o_lsu_ready, o_alu_ready,
        input  o_wb_qry_rs1_busy, o_wb_qry_rs2_busy,
        input  o_gpr_wr_en, o_gpr_wr_id, o_gpr_wr_data,
        input  o_wb_count, o_wb_idle
    );
endinterface

// File: rtl/gpr_wb.sv
// Writeback queue: merges LSU/ALU results (LSU first) into an in-order FIFO
// that drains one entry per cycle into the GPR write port, with hazard lookup.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif

module gpr_wb #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int GPRS_WIDTH = `GPRS_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic     i_sys_clk,
    input  logic     i_sys_rst_n,
    gpr_wb_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_en_q, wr_en_d;
    logic [GPRS_WIDTH-1:0] wr_id_q, wr_id_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic [GPRS_WIDTH-1:0] id_mem_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

    logic                  full, lsu_fire, alu_fire, push, pop;
    logic [GPRS_WIDTH-1:0] acc_id;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [DEPTH-1:0]      rs1_hit, rs2_hit;

    // No pass-through when full: readies depend on count only, not on a same-cycle pop.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign lsu_fire = bus.i_lsu_valid && !full;
    assign alu_fire = bus.i_alu_valid && !full && !bus.i_lsu_valid;
    assign acc_id   = lsu_fire ? bus.i_lsu_id   : bus.i_alu_id;
    assign acc_data = lsu_fire ? bus.i_lsu_data : bus.i_alu_data;
    assign push     = (lsu_fire || alu_fire) && (acc_id != '0);
    assign pop      = (count_q != '0) && !bus.i_wb_stall;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_en_d   = pop;
        wr_id_d   = wr_id_q;
        wr_data_d = wr_data_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d    = head_q + 1'b1;
            wr_id_d   = id_mem_q[head_q];
            wr_data_d = data_mem_q[head_q];
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_id_q   <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_id_q   <= wr_id_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n && push) begin
            id_mem_q[tail_q]   <= acc_id;
            data_mem_q[tail_q] <= acc_data;
        end
    end

    // A slot is live when its distance from head (mod DEPTH) is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] slot_off;
            logic             slot_valid;
            assign slot_off    = PTR_W'(gi) - head_q;
            assign slot_valid  = ({1'b0, slot_off} < count_q);
            assign rs1_hit[gi] = slot_valid && (id_mem_q[gi] == bus.i_wb_qry_rs1_id);
            assign rs2_hit[gi] = slot_valid && (id_mem_q[gi] == bus.i_wb_qry_rs2_id);
        end
    endgenerate

    assign bus.o_wb_qry_rs1_busy = (bus.i_wb_qry_rs1_id != '0) &&
        ((|rs1_hit) || (wr_en_q && (wr_id_q == bus.i_wb_qry_rs1_id)));
    assign bus.o_wb_qry_rs2_busy = (bus.i_wb_qry_rs2_id != '0) &&
        ((|rs2_hit) || (wr_en_q && (wr_id_q == bus.i_wb_qry_rs2_id)));

    assign bus.o_lsu_ready   = !full;
    assign bus.o_alu_ready   = !full && !bus.i_lsu_valid;
    assign bus.o_gpr_wr_en   = wr_en_q;
    assign bus.o_gpr_wr_id   = wr_id_q;
    assign bus.o_gpr_wr_data = wr_data_q;
    assign bus.o_wb_count    = count_q;
    assign bus.o_wb_idle     = (count_q == '0) && !wr_en_q;
endmodule

// File: tb/tb_gpr_wb.sv
// Directed bench for gpr_wb: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_gpr_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    gpr_wb_if #(.DATA_WIDTH(32), .GPRS_WIDTH(5), .DEPTH(4)) bus ();

    gpr_wb #(.DATA_WIDTH(32), .GPRS_WIDTH(5), .DEPTH(4)) dut (
        .i_sys_clk   (clk),
        .i_sys_rst_n (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic alu_drive(input logic v, input logic [4:0] id, input logic [31:0] d);
        bus.i_alu_valid = v;
        bus.i_alu_id    = id;
        bus.i_alu_data  = d;
    endtask

    int sent;
    int seen;

    initial begin
        bus.i_lsu_valid = 0; bus.i_lsu_id = '0; bus.i_lsu_data = '0;
        alu_drive(0, 5'd0, 32'd0);
        bus.i_wb_stall = 0;
        bus.i_wb_qry_rs1_id = '0; bus.i_wb_qry_rs2_id = '0;

        // reset state
        tick(); tick();
        rst = 0;
        settle();
        check("rst_count", bus.o_wb_count, 0);
        check("rst_idle", bus.o_wb_idle, 1);
        check("rst_wr_en", bus.o_gpr_wr_en, 0);
        check("rst_wr_id", bus.o_gpr_wr_id, 0);
        check("rst_wr_data", bus.o_gpr_wr_data, 0);
        check("rst_lsu_ready", bus.o_lsu_ready, 1);
        check("rst_alu_ready", bus.o_alu_ready, 1);

        // basic path: ALU id5 accepted in cycle 0, write in cycle 2
        tick(); alu_drive(1, 5'd5, 32'hDEADBEEF); bus.i_wb_qry_rs1_id = 5'd5;
        settle();
        check("basic_c0_ready", bus.o_alu_ready, 1);
        check("basic_c0_busy", bus.o_wb_qry_rs1_busy, 0);
        tick(); alu_drive(0, 5'd0, 32'd0);
        settle();
        check("basic_c1_count", bus.o_wb_count, 1);
        check("basic_c1_busy", bus.o_wb_qry_rs1_busy, 1);
        check("basic_c1_wr_en", bus.o_gpr_wr_en, 0);
        tick(); settle();
        check("basic_c2_wr_en", bus.o_gpr_wr_en, 1);
        check("basic_c2_wr_id", bus.o_gpr_wr_id, 5);
        check("basic_c2_wr_data", bus.o_gpr_wr_data, 32'hDEADBEEF);
        check("basic_c2_busy", bus.o_wb_qry_rs1_busy, 1);
        tick(); settle();
        check("basic_c3_wr_en", bus.o_gpr_wr_en, 0);
        check("basic_c3_busy", bus.o_wb_qry_rs1_busy, 0);
        check("basic_c3_hold_id", bus.o_gpr_wr_id, 5);
        check("basic_c3_hold_data", bus.o_gpr_wr_data, 32'hDEADBEEF);
        check("basic_c3_idle", bus.o_wb_idle, 1);

        // priority: LSU wins, ALU follows next cycle
        tick();
        bus.i_lsu_valid = 1; bus.i_lsu_id = 5'd3; bus.i_lsu_data = 32'h11;
        alu_drive(1, 5'd4, 32'h22);
        settle();
        check("prio_alu_ready", bus.o_alu_ready, 0);
        check("prio_lsu_ready", bus.o_lsu_ready, 1);
        tick(); bus.i_lsu_valid = 0;
        settle();
        check("prio_alu_ready2", bus.o_alu_ready, 1);
        check("prio_count", bus.o_wb_count, 1);
        tick(); alu_drive(0, 5'd0, 32'd0);
        settle();
        check("prio_w1_en", bus.o_gpr_wr_en, 1);
        check("prio_w1_id", bus.o_gpr_wr_id, 3);
        check("prio_w1_data", bus.o_gpr_wr_data, 32'h11);
        tick(); settle();
        check("prio_w2_en", bus.o_gpr_wr_en, 1);
        check("prio_w2_id", bus.o_gpr_wr_id, 4);
        check("prio_w2_data", bus.o_gpr_wr_data, 32'h22);
        tick(); settle();
        check("prio_after_en", bus.o_gpr_wr_en, 0);

        // full under stall, then drain in order; LSU offer while full is refused
        for (int k = 1; k <= 4; k++) begin
            tick(); bus.i_wb_stall = 1; alu_drive(1, 5'(k), 32'hA0 + 32'(k));
            settle();
            check("full_fill_ready", bus.o_alu_ready, 1);
        end
        tick(); alu_drive(0, 5'd0, 32'd0); bus.i_wb_stall = 0;
        bus.i_lsu_valid = 1; bus.i_lsu_id = 5'd9; bus.i_lsu_data = 32'h99;
        bus.i_wb_qry_rs2_id = 5'd9;
        settle();
        check("full_count", bus.o_wb_count, 4);
        check("full_lsu_ready", bus.o_lsu_ready, 0);
        check("full_alu_ready", bus.o_alu_ready, 0);
        check("full_wr_en", bus.o_gpr_wr_en, 0);
        tick(); bus.i_lsu_valid = 0;
        settle();
        check("drain_count", bus.o_wb_count, 3);
        check("drain_lsu_ready", bus.o_lsu_ready, 1);
        check("drain_rs2_busy", bus.o_wb_qry_rs2_busy, 0);
        check("drain_w1_en", bus.o_gpr_wr_en, 1);
        check("drain_w1_id", bus.o_gpr_wr_id, 1);
        check("drain_w1_data", bus.o_gpr_wr_data, 32'hA1);
        for (int k = 2; k <= 4; k++) begin
            tick(); settle();
            check("drain_en", bus.o_gpr_wr_en, 1);
            check("drain_id", bus.o_gpr_wr_id, k);
            check("drain_data", bus.o_gpr_wr_data, 32'hA0 + k);
        end
        tick(); settle();
        check("drain_done_en", bus.o_gpr_wr_en, 0);
        check("drain_done_count", bus.o_wb_count, 0);

        // x0 result is consumed and dropped
        tick(); alu_drive(1, 5'd0, 32'hFFFFFFFF);
        bus.i_wb_qry_rs1_id = 5'd0; bus.i_wb_qry_rs2_id = 5'd0;
        settle();
        check("x0_ready", bus.o_alu_ready, 1);
        tick(); alu_drive(0, 5'd0, 32'd0);
        settle();
        check("x0_count", bus.o_wb_count, 0);
        check("x0_busy", bus.o_wb_qry_rs1_busy, 0);
        check("x0_wr_en1", bus.o_gpr_wr_en, 0);
        tick(); settle();
        check("x0_wr_en2", bus.o_gpr_wr_en, 0);
        check("x0_idle", bus.o_wb_idle, 1);

        // wrap with same id: 10 accepts of id7, stall pattern forces fill and wrap
        bus.i_wb_qry_rs1_id = 5'd7;
        sent = 0; seen = 0;
        for (int cyc = 0; cyc < 200 && seen < 10; cyc++) begin
            tick();
            bus.i_wb_stall = ((cyc % 5) < 2);
            if (sent < 10) alu_drive(1, 5'd7, 32'(sent + 1));
            else           alu_drive(0, 5'd0, 32'd0);
            settle();
            if (bus.i_alu_valid && bus.o_alu_ready) begin
                sent++;
                $display("tx  accept id=7 data=%0d cycle=%0d", sent, cyc);
            end
            if (cyc >= 1) check("wrap_busy", bus.o_wb_qry_rs1_busy, 1);
            if (bus.o_gpr_wr_en) begin
                check("wrap_id", bus.o_gpr_wr_id, 7);
                check("wrap_data", bus.o_gpr_wr_data, seen + 1);
                seen++;
            end
        end
        check("wrap_writes", seen, 10);
        tick(); alu_drive(0, 5'd0, 32'd0); bus.i_wb_stall = 0;
        settle();
        check("wrap_end_busy", bus.o_wb_qry_rs1_busy, 0);
        check("wrap_end_idle", bus.o_wb_idle, 1);

        // reset with count=3 and a write in flight
        for (int k = 1; k <= 4; k++) begin
            tick(); bus.i_wb_stall = 1; alu_drive(1, 5'(k), 32'hB0 + 32'(k));
            settle();
        end
        tick(); alu_drive(0, 5'd0, 32'd0); bus.i_wb_stall = 0;
        settle();
        tick(); rst = 1; alu_drive(1, 5'd5, 32'h55);
        settle();
        check("mid_pre_wr_en", bus.o_gpr_wr_en, 1);
        check("mid_pre_count", bus.o_wb_count, 3);
        tick(); rst = 0; alu_drive(0, 5'd0, 32'd0);
        bus.i_wb_qry_rs1_id = 5'd2; bus.i_wb_qry_rs2_id = 5'd5;
        settle();
        check("mid_count", bus.o_wb_count, 0);
        check("mid_wr_en", bus.o_gpr_wr_en, 0);
        check("mid_idle", bus.o_wb_idle, 1);
        check("mid_wr_id", bus.o_gpr_wr_id, 0);
        check("mid_busy1", bus.o_wb_qry_rs1_busy, 0);
        check("mid_busy2", bus.o_wb_qry_rs2_busy, 0);
        check("mid_ready", bus.o_alu_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            check("mid_quiet_en", bus.o_gpr_wr_en, 0);
            check("mid_quiet_count", bus.o_wb_count, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
